// File: rtl/cnn_mac_seq_pkg.sv
// Shared widths, multiplier latency and FSM state type for the dot-product
// sequencer that feeds the 24s x 8s pipelined DSP multiplier.
package cnn_mac_pkg;

    localparam int A_W_DEF   = 24;
    localparam int B_W_DEF   = 8;
    localparam int P_W_DEF   = 30;
    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 12;
    localparam int MUL_LAT   = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_e;

endpackage

// File: rtl/cnn_mac_seq_if.sv
// Job, operand, multiplier and result signals of the MAC sequencer.
// master = loop control / multiplier side, slave = the sequencer.
interface cnn_mac_seq_if #(
    parameter int A_W   = cnn_mac_pkg::A_W_DEF,
    parameter int B_W   = cnn_mac_pkg::B_W_DEF,
    parameter int P_W   = cnn_mac_pkg::P_W_DEF,
    parameter int ACC_W = cnn_mac_pkg::ACC_W_DEF,
    parameter int LEN_W = cnn_mac_pkg::LEN_W_DEF
);

    logic                    start;
    logic [LEN_W-1:0]        len;
    logic signed [ACC_W-1:0] bias;
    logic                    busy;

    logic                    op_valid;
    logic                    op_ready;
    logic signed [A_W-1:0]   op_a;
    logic signed [B_W-1:0]   op_b;

    logic                    mul_ce;
    logic signed [A_W-1:0]   mul_din0;
    logic signed [B_W-1:0]   mul_din1;
    logic signed [P_W-1:0]   mul_dout;

    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;
    logic                    res_ovf;

    modport master (
        output start, len, bias, op_valid, op_a, op_b, mul_dout, res_ready,
        input  busy, op_ready, mul_ce, mul_din0, mul_din1, res_valid, res_data, res_ovf
    );

    modport slave (
        input  start, len, bias, op_valid, op_a, op_b, mul_dout, res_ready,
        output busy, op_ready, mul_ce, mul_din0, mul_din1, res_valid, res_data, res_ovf
    );

endinterface

// File: rtl/cnn_mac_seq.sv
// Dot-product sequencer: issues operand pairs into the two-stage multiplier,
// tracks in-flight products and accumulates them onto a bias-preloaded sum.
module cnn_mac_seq
    import cnn_mac_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input logic          clk,
    input logic          reset,
    cnn_mac_seq_if.slave bus
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [LEN_W-1:0]        iss_cnt_q, iss_cnt_d;
    logic [LEN_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic                    v0_q, v0_d;
    logic                    v1_q, v1_d;

    logic                    opReady;
    logic                    mulCe;
    logic                    fire;
    logic signed [ACC_W-1:0] prodExt;
    logic signed [ACC_W-1:0] sum;
    logic                    ovfStep;

    assign opReady = (state_q == RUN);
    assign mulCe   = (state_q == RUN) || (state_q == DRAIN);
    assign fire    = bus.op_valid && opReady;

    // The signed cast sign-extends a narrow product or wraps a wide one.
    assign prodExt = ACC_W'(bus.mul_dout);
    assign sum     = acc_q + prodExt;
    assign ovfStep = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_q[ACC_W-1]);

    assign bus.busy      = (state_q != IDLE);
    assign bus.op_ready  = opReady;
    assign bus.mul_ce    = mulCe;
    assign bus.mul_din0  = bus.op_a;
    assign bus.mul_din1  = bus.op_b;
    assign bus.res_valid = (state_q == HOLD);
    assign bus.res_data  = acc_q;
    assign bus.res_ovf   = ovf_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        iss_cnt_d = iss_cnt_q;
        acc_cnt_d = acc_cnt_q;
        v0_d      = v0_q;
        v1_d      = v1_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = bus.bias;
                    ovf_d = 1'b0;
                    if (bus.len != '0) begin
                        iss_cnt_d = bus.len;
                        acc_cnt_d = bus.len;
                        state_d   = RUN;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    iss_cnt_d = iss_cnt_q - LEN_W'(1);
                    if (iss_cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The valid pipeline mirrors the multiplier stages, so it only moves with ce.
        if (mulCe) begin
            v0_d = fire;
            v1_d = v0_q;
            if (v1_q) begin
                acc_d     = sum;
                ovf_d     = ovf_q | ovfStep;
                acc_cnt_d = acc_cnt_q - LEN_W'(1);
                if (acc_cnt_q == LEN_W'(1)) begin
                    state_d = HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            iss_cnt_q <= '0;
            acc_cnt_q <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            iss_cnt_q <= iss_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
        end
    end

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Scoreboard bench for cnn_mac_seq: directed jobs push expected results,
// per-instance monitors pop and compare whenever a result is handed over.
module tb_cnn_mac_seq;
    import cnn_mac_pkg::*;

    typedef struct {
        string              name;
        logic signed [39:0] data;
        logic               ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int popCount = 0;
    int popCount5 = 0;
    int riseCycle = -1;
    logic prevValid = 1'b0;

    exp_t sbq[$];
    exp_t sbq5[$];
    int vecA[$];
    int vecB[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: 32-bit product bus so the full-range 24x8 product is exact.
    cnn_mac_seq_if #(.P_W(32)) bus ();
    cnn_mac_seq #(.P_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Narrow-accumulator instance used for the overflow/wrap case.
    cnn_mac_seq_if #(.ACC_W(30)) bus5 ();
    cnn_mac_seq #(.ACC_W(30)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

    // Behavioural two-stage multipliers gated by ce.
    logic signed [63:0] prodFull, prodFull5;
    logic [31:0] m1, m2;
    logic [29:0] n1, n2;
    assign prodFull  = 64'(bus.mul_din0) * 64'(bus.mul_din1);
    assign prodFull5 = 64'(bus5.mul_din0) * 64'(bus5.mul_din1);
    assign bus.mul_dout  = m2;
    assign bus5.mul_dout = n2;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1 <= '0; m2 <= '0; n1 <= '0; n2 <= '0;
        end else begin
            if (bus.mul_ce) begin
                m1 <= prodFull[31:0];
                m2 <= m1;
            end
            if (bus5.mul_ce) begin
                n1 <= prodFull5[29:0];
                n2 <= n1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d required=%0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.res_valid && !prevValid) riseCycle = cyc;
            prevValid = bus.res_valid;
            if (bus.res_valid && bus.res_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result got=%0d required=none", bus.res_data);
                end else begin
                    e = sbq.pop_front();
                    checkOutput({e.name, "_data"}, 64'(bus.res_data), 64'(e.data));
                    checkOutput({e.name, "_ovf"}, 64'(bus.res_ovf), 64'(e.ovf));
                    popCount++;
                end
            end
        end else begin
            prevValid = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus5.res_valid && bus5.res_ready) begin
            if (sbq5.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_result5 got=%0d required=none", bus5.res_data);
            end else begin
                e = sbq5.pop_front();
                checkOutput({e.name, "_data"}, 64'(bus5.res_data), 64'(e.data));
                checkOutput({e.name, "_ovf"}, 64'(bus5.res_ovf), 64'(e.ovf));
                popCount5++;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_op_ready"}, 64'(bus.op_ready), 64'd0);
        checkOutput({tag, "_mul_ce"}, 64'(bus.mul_ce), 64'd0);
        checkOutput({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        checkOutput({tag, "_res_ovf"}, 64'(bus.res_ovf), 64'd0);
        checkOutput({tag, "_res_data"}, 64'(bus.res_data), 64'd0);
    endtask

    // Starts a job on the main instance and streams vecA/vecB with gap idle
    // cycles between pairs; t0 is the first cycle operands can be accepted.
    task automatic applyStimulus(input int len, input longint bias, input int gap,
                                 output int t0);
        int k;
        bus.start = 1'b1;
        bus.len   = 12'(len);
        bus.bias  = 40'(bias);
        @(posedge clk); #1;
        bus.start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < vecA.size(); i++) begin
            bus.op_valid = 1'b1;
            bus.op_a     = 24'(vecA[i]);
            bus.op_b     = 8'(vecB[i]);
            k = 0;
            while (!bus.op_ready && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            @(posedge clk); #1;
            bus.op_valid = 1'b0;
            bus.op_a     = 24'd77;
            bus.op_b     = 8'd3;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic waitPops(input int target, input string name);
        int k = 0;
        while (popCount < target && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (popCount < target) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout got=%0d required=%0d", name, popCount, target);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int k;
        bus.start = 0; bus.len = '0; bus.bias = '0; bus.op_valid = 0;
        bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b1;
        bus5.start = 0; bus5.len = '0; bus5.bias = '0; bus5.op_valid = 0;
        bus5.op_a = '0; bus5.op_b = '0; bus5.res_ready = 1'b0;

        #1;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Case 1: four back-to-back pairs, result rises six cycles after t0.
        vecA = '{1, 2, 3, 4};
        vecB = '{1, 1, 1, 1};
        sbq.push_back('{"c1", 40'sd10, 1'b0});
        applyStimulus(4, 0, 0, t0);
        waitPops(1, "c1");
        checkOutput("c1_latency", 64'(riseCycle - t0), 64'd6);
        @(posedge clk); #1;

        // Case 2: most negative operands give the largest positive product.
        vecA = '{-8388608};
        vecB = '{-128};
        sbq.push_back('{"c2", 40'sd1073741824, 1'b0});
        applyStimulus(1, 0, 0, t0);
        waitPops(2, "c2");
        @(posedge clk); #1;

        // Case 3: gaps between pairs must not add stale multiplier output.
        vecA = '{5, -7, 100};
        vecB = '{3, 2, -1};
        sbq.push_back('{"c3", 40'sd901, 1'b0});
        applyStimulus(3, 1000, 2, t0);
        waitPops(3, "c3");
        @(posedge clk); #1;

        // Case 4: empty job returns the bias immediately.
        vecA = {};
        vecB = {};
        sbq.push_back('{"c4", -40'sd5, 1'b0});
        applyStimulus(0, -5, 0, t0);
        checkOutput("c4_valid_next", 64'(bus.res_valid), 64'd1);
        checkOutput("c4_mul_ce", 64'(bus.mul_ce), 64'd0);
        waitPops(4, "c4");
        @(posedge clk); #1;

        // Case 5: each product fits the 30-bit bus but their sum wraps a 30-bit accumulator.
        bus5.start = 1'b1;
        bus5.len   = 12'd2;
        bus5.bias  = '0;
        @(posedge clk); #1;
        bus5.start    = 1'b0;
        bus5.op_valid = 1'b1;
        bus5.op_a     = 24'sd4194304;
        bus5.op_b     = 8'sd127;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus5.op_valid = 1'b0;
        k = 0;
        while (!bus5.res_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("c5_reached_hold", 64'(bus5.res_valid), 64'd1);
        bus5.start = 1'b1;
        bus5.len   = 12'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("c5_hold_data", 64'(bus5.res_data), -64'sd8388608);
            checkOutput("c5_hold_valid", 64'(bus5.res_valid), 64'd1);
        end
        sbq5.push_back('{"c5", -40'sd8388608, 1'b1});
        bus5.start     = 1'b0;
        bus5.res_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("c5_popped", 64'(popCount5), 64'd1);
        checkOutput("c5_idle_after", 64'(bus5.busy), 64'd0);

        // Case 6: reset in the middle of a job, then a clean job.
        bus.start = 1'b1;
        bus.len   = 12'd4;
        bus.bias  = 40'sd123;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a     = 24'sd1;
        bus.op_b     = 8'sd1;
        @(posedge clk); #1;
        bus.op_a     = 24'sd2;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        checkOutput("c6_pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        checkResetOutputs("c6_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        vecA = '{1, 2, 3, 4};
        vecB = '{1, 1, 1, 1};
        sbq.push_back('{"c6", 40'sd10, 1'b0});
        applyStimulus(4, 0, 0, t0);
        waitPops(5, "c6");
        @(posedge clk); #1;

        checkOutput("sb_empty", 64'(sbq.size() + sbq5.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
